// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and
// architectural constants used by fetch_unit and ifid_reg.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_RESET = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'h0000_0004;
   localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority per cycle: reset, flush (bubble),
// stall (hold), load (new instruction), bubble, otherwise hold.
// A bubble keeps the previous pc field and only clears valid/instr.
module ifid_reg
   import fetch_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;

   // Update the IF/ID contents according to flush/stall/load/bubble priority.
   always_ff @(posedge clk_i) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of block ordering in simulation.
      if (!rst_i) begin
         r_pc    <= PC_RESET;
         r_instr <= NOP;
         r_valid <= 1'b0;
      end else if (flush_i) begin
         r_instr <= NOP;
         r_valid <= 1'b0;
      end else if (stall_i) begin
         r_valid <= r_valid;
      end else if (load_i) begin
         r_pc    <= pc_i;
         r_instr <= instr_i;
         r_valid <= 1'b1;
      end else if (bubble_i) begin
         r_instr <= NOP;
         r_valid <= 1'b0;
      end
   end

   assign pc_o    = r_pc;
   assign instr_o = r_instr;
   assign valid_o = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FETCH/HOLD controller, program counter,
// one-entry holding buffer for instructions that arrive while the pipeline
// is stalled, and kill tracking for redirects that hit an outstanding request.
module fetch_unit
   import fetch_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        PCWrite_i,
   input  logic        IFIDStall_i,
   input  logic        IFIDFlush_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_IFID_o,
   output logic [31:0] instr_IFID_o,
   output logic        valid_IFID_o
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic         r_req;
   logic         r_buf_valid;
   logic [31:0]  r_buf_pc;
   logic [31:0]  r_buf_instr;
   logic         r_kill;
   logic [31:0]  r_kill_target;

   logic         w_advance;
   logic         w_ifid_load;
   logic         w_ifid_bubble;
   logic [31:0]  w_ifid_pc;
   logic [31:0]  w_ifid_instr;

   // The pipeline may accept a new instruction only when neither stall nor PC freeze is active.
   assign w_advance = !IFIDStall_i && PCWrite_i;

   // Select what the IF/ID register receives this cycle (flush/stall priority lives in ifid_reg).
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      w_ifid_load   = 1'b0;
      w_ifid_bubble = 1'b0;
      w_ifid_pc     = r_buf_pc;
      w_ifid_instr  = r_buf_instr;
      case (r_state)
         FETCH: begin
            if (imem_ready_i && !r_kill && w_advance) begin
               w_ifid_load  = 1'b1;
               w_ifid_pc    = r_pc;
               w_ifid_instr = imem_data_i;
            end else if (!imem_ready_i || r_kill) begin
               w_ifid_bubble = 1'b1;
            end
         end
         HOLD: begin
            w_ifid_load = r_buf_valid && w_advance;
         end
         default: begin
         end
      endcase
   end

   // Controller, PC, holding buffer and kill tracking.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state       <= IDLE;
         r_pc          <= PC_RESET;
         r_req         <= 1'b0;
         r_buf_valid   <= 1'b0;
         r_buf_pc      <= PC_RESET;
         r_buf_instr   <= NOP;
         r_kill        <= 1'b0;
         r_kill_target <= PC_RESET;
      end else begin
         case (r_state)
            IDLE: begin
               if (IFIDFlush_i) r_pc <= branch_target_i;
               if (start_i) begin
                  r_state <= FETCH;
                  r_req   <= 1'b1;
               end
            end
            FETCH: begin
               if (imem_ready_i) begin
                  if (IFIDFlush_i) begin
                     // Transfer completes but is dropped; redirect immediately.
                     r_pc   <= branch_target_i;
                     r_kill <= 1'b0;
                  end else if (r_kill) begin
                     // Killed transfer finally completes: discard and redirect.
                     r_pc   <= r_kill_target;
                     r_kill <= 1'b0;
                  end else if (w_advance) begin
                     r_pc <= r_pc + PC_STEP;
                  end else begin
                     r_buf_valid <= 1'b1;
                     r_buf_pc    <= r_pc;
                     r_buf_instr <= imem_data_i;
                     r_state     <= HOLD;
                     r_req       <= 1'b0;
                  end
               end else if (IFIDFlush_i) begin
                  // Request must stay stable until it completes; remember the redirect.
                  r_kill        <= 1'b1;
                  r_kill_target <= branch_target_i;
               end
            end
            HOLD: begin
               if (IFIDFlush_i) begin
                  r_buf_valid <= 1'b0;
                  r_pc        <= branch_target_i;
                  r_state     <= FETCH;
                  r_req       <= 1'b1;
               end else if (w_advance) begin
                  r_buf_valid <= 1'b0;
                  r_pc        <= r_pc + PC_STEP;
                  r_state     <= FETCH;
                  r_req       <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_o  = r_req;
   assign imem_addr_o = r_pc;

   ifid_reg u_ifid_reg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush_i  (IFIDFlush_i),
      .stall_i  (IFIDStall_i),
      .load_i   (w_ifid_load),
      .bubble_i (w_ifid_bubble),
      .pc_i     (w_ifid_pc),
      .instr_i  (w_ifid_instr),
      .pc_o     (pc_IFID_o),
      .instr_o  (instr_IFID_o),
      .valid_o  (valid_IFID_o)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// multi-cycle corner sequences, and a randomized run against a queue-based
// reference model of the fetch stage.
module tb_fetch_unit;

   localparam logic [31:0] NOP_I = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, PCWrite_i, IFIDStall_i, IFIDFlush_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_data_i;
   logic [31:0] pc_IFID_o, instr_IFID_o;
   logic        valid_IFID_o;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk_i = ~clk_i;

   fetch_unit dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .PCWrite_i       (PCWrite_i),
      .IFIDStall_i     (IFIDStall_i),
      .IFIDFlush_i     (IFIDFlush_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ready_i    (imem_ready_i),
      .imem_data_i     (imem_data_i),
      .pc_IFID_o       (pc_IFID_o),
      .instr_IFID_o    (instr_IFID_o),
      .valid_IFID_o    (valid_IFID_o)
   );

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
   endfunction

   always_comb imem_data_i = instr_of(imem_addr_o);

   // ---------------- reference model ----------------
   bit          m_run;
   logic [31:0] m_held[$];
   bit          m_kill;
   logic [31:0] m_ktgt;
   logic [31:0] m_pc;
   bit          m_if_valid;
   logic [31:0] m_if_pc, m_if_instr;

   task automatic m_bubble();
      m_if_valid = 1'b0;
      m_if_instr = NOP_I;
   endtask

   task automatic model_step(input bit rst, start, pcw, stall, flush,
                             input logic [31:0] tgt, input bit ready);
      bit advance;
      advance = !stall && pcw;
      if (!rst) begin
         m_run = 0; m_held.delete(); m_kill = 0; m_ktgt = 0; m_pc = 0;
         m_if_valid = 0; m_if_pc = 0; m_if_instr = NOP_I;
      end else if (!m_run) begin
         if (flush) begin m_pc = tgt; m_bubble(); end
         if (start) m_run = 1;
      end else if (m_held.size() > 0) begin
         if (flush) begin
            m_held.delete(); m_pc = tgt; m_bubble();
         end else if (advance) begin
            m_if_pc = m_held.pop_front();
            m_if_instr = instr_of(m_if_pc);
            m_if_valid = 1'b1;
            m_pc = m_pc + 32'd4;
         end
      end else begin
         if (flush) begin
            m_bubble();
            if (ready) begin m_pc = tgt; m_kill = 0; end
            else begin m_kill = 1; m_ktgt = tgt; end
         end else if (ready) begin
            if (m_kill) begin
               m_pc = m_ktgt; m_kill = 0;
               if (!stall) m_bubble();
            end else if (advance) begin
               m_if_pc = m_pc; m_if_instr = instr_of(m_pc); m_if_valid = 1'b1;
               m_pc = m_pc + 32'd4;
            end else begin
               m_held.push_back(m_pc);
            end
         end else if (!stall) begin
            m_bubble();
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic expect_out(input string tag, input bit e_req, input logic [31:0] e_addr,
                             input bit e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
      check({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, e_req});
      if (e_req) check({tag, ".addr"}, imem_addr_o, e_addr);
      check({tag, ".valid"}, {31'd0, valid_IFID_o}, {31'd0, e_valid});
      check({tag, ".instr"}, instr_IFID_o, e_instr);
      if (e_valid) check({tag, ".pc"}, pc_IFID_o, e_pc);
   endtask

   task automatic compare_model(input string tag);
      bit e_req;
      e_req = m_run && (m_held.size() == 0);
      expect_out(tag, e_req, m_pc, m_if_valid, m_if_pc, m_if_instr);
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
   task automatic cycle(input bit rst, start, pcw, stall, flush,
                        input logic [31:0] tgt, input bit ready);
      rst_i = rst; start_i = start; PCWrite_i = pcw; IFIDStall_i = stall;
      IFIDFlush_i = flush; branch_target_i = tgt; imem_ready_i = ready;
      @(posedge clk_i);
      model_step(rst, start, pcw, stall, flush, tgt, ready);
      #1;
   endtask

   typedef struct {
      bit          rst, start, pcw, stall, flush, ready;
      logic [31:0] tgt;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   function automatic vec_t mk(input bit rst, start, pcw, stall, ready,
                               input bit e_req, input logic [31:0] e_addr,
                               input bit e_valid, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.start = start; v.pcw = pcw; v.stall = stall; v.flush = 1'b0;
      v.ready = ready; v.tgt = 32'h0;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      v.e_instr = e_valid ? instr_of(e_pc) : NOP_I;
      return v;
   endfunction

   initial begin
      vec_t vecs[9];
      bit r_rst, r_start, r_pcw, r_stall, r_flush, r_ready;
      logic [31:0] r_tgt;

      rst_i = 1'b0; start_i = 1'b0; PCWrite_i = 1'b1; IFIDStall_i = 1'b0;
      IFIDFlush_i = 1'b0; branch_target_i = 32'h0; imem_ready_i = 1'b0;

      // Straight-line fetch, then a two-cycle stall at pc=8 and release.
      //            rst st pcw stl rdy  req addr   val pc
      vecs[0] = mk(0, 0, 1, 0, 0,   0, 32'h0,  0, 32'h0);
      vecs[1] = mk(1, 1, 1, 0, 1,   1, 32'h0,  0, 32'h0);
      vecs[2] = mk(1, 0, 1, 0, 1,   1, 32'h4,  1, 32'h0);
      vecs[3] = mk(1, 0, 1, 0, 1,   1, 32'h8,  1, 32'h4);
      vecs[4] = mk(1, 0, 0, 1, 1,   0, 32'h8,  1, 32'h4);
      vecs[5] = mk(1, 0, 0, 1, 1,   0, 32'h8,  1, 32'h4);
      vecs[6] = mk(1, 0, 1, 0, 0,   1, 32'hC,  1, 32'h8);
      vecs[7] = mk(1, 0, 1, 0, 0,   1, 32'hC,  0, 32'h8);
      vecs[8] = mk(1, 0, 1, 0, 1,   1, 32'h10, 1, 32'hC);

      for (int i = 0; i < 9; i++) begin
         cycle(vecs[i].rst, vecs[i].start, vecs[i].pcw, vecs[i].stall,
               vecs[i].flush, vecs[i].tgt, vecs[i].ready);
         expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
         if (i == 0) check("reset.pc_ifid", pc_IFID_o, 32'h0);
      end

      // Flush while stalled in HOLD: buffered instruction is dropped.
      cycle(0, 0, 1, 0, 0, 32'h0, 0);
      cycle(1, 1, 1, 0, 0, 32'h0, 0);
      expect_out("hold.start", 1, 32'h0, 0, 32'h0, NOP_I);
      cycle(1, 0, 0, 1, 0, 32'h0, 1);
      expect_out("hold.enter", 0, 32'h0, 0, 32'h0, NOP_I);
      cycle(1, 0, 0, 1, 1, 32'h100, 0);
      expect_out("hold.flush", 1, 32'h100, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("hold.after", 1, 32'h104, 1, 32'h100, instr_of(32'h100));

      // Flush with ready=1 drops the data; then flush during a pending request.
      cycle(1, 0, 1, 0, 1, 32'h20, 1);
      expect_out("flush.rdy", 1, 32'h20, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 1, 32'h200, 0);
      expect_out("kill.set", 1, 32'h20, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 0);
      expect_out("kill.wait1", 1, 32'h20, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 0);
      expect_out("kill.wait2", 1, 32'h20, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("kill.drop", 1, 32'h200, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("kill.next", 1, 32'h204, 1, 32'h200, instr_of(32'h200));

      // Second flush while kill pending overwrites the stored target.
      cycle(1, 0, 1, 0, 1, 32'h400, 0);
      cycle(1, 0, 1, 0, 1, 32'h480, 0);
      expect_out("kill2.wait", 1, 32'h204, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("kill2.drop", 1, 32'h480, 0, 32'h0, NOP_I);

      // PC wrap-around.
      cycle(1, 0, 1, 0, 1, 32'hFFFF_FFFC, 1);
      expect_out("wrap.redirect", 1, 32'hFFFF_FFFC, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("wrap.next", 1, 32'h0, 1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC));

      // Reset during a pending request.
      cycle(1, 0, 1, 0, 0, 32'h0, 0);
      cycle(0, 0, 1, 0, 0, 32'h0, 0);
      expect_out("rst.mid", 0, 32'h0, 0, 32'h0, NOP_I);
      check("rst.mid.pc_ifid", pc_IFID_o, 32'h0);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("rst.idle1", 0, 32'h0, 0, 32'h0, NOP_I);
      cycle(1, 0, 1, 0, 0, 32'h0, 1);
      expect_out("rst.idle2", 0, 32'h0, 0, 32'h0, NOP_I);
      cycle(1, 1, 1, 0, 0, 32'h0, 1);
      expect_out("rst.restart", 1, 32'h0, 0, 32'h0, NOP_I);

      // Randomized run against the reference model.
      cycle(0, 0, 1, 0, 0, 32'h0, 0);
      compare_model("rnd.reset");
      for (int i = 0; i < 3000; i++) begin
         r_rst   = ($urandom_range(0, 199) != 0);
         r_start = ($urandom_range(0, 3) == 0);
         r_pcw   = ($urandom_range(0, 4) != 0);
         r_stall = ($urandom_range(0, 3) == 0);
         r_flush = ($urandom_range(0, 11) == 0);
         r_ready = ($urandom_range(0, 2) != 0);
         r_tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         cycle(r_rst, r_start, r_pcw, r_stall, r_flush, r_tgt, r_ready);
         compare_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port start_i, input, 1, level; enables fetching after reset.
REQ-004 SHALL have port PCWrite_i, input, 1, from hazard detection; 0 freezes PC.
REQ-005 SHALL have port IFIDStall_i, input, 1, from hazard detection; 1 holds IF/ID register.
REQ-006 SHALL have port IFIDFlush_i, input, 1, from hazard detection; 1 = taken branch, redirect and squash.
REQ-007 SHALL have port branch_target_i, input, 32, redirect PC, sampled when IFIDFlush_i=1.
REQ-008 SHALL have ports imem_req_o (output, 1), imem_addr_o (output, 32), imem_ready_i (input, 1), imem_data_i (input, 32); transfer occurs on a cycle with req=1 and ready=1, with data valid in that cycle.
REQ-009 SHALL have outputs pc_IFID_o (32), instr_IFID_o (32), valid_IFID_o (1), the IF/ID pipeline register contents.

Function
REQ-010 SHALL implement states IDLE, FETCH, HOLD; IDLE->FETCH when start_i=1; start_i is ignored outside IDLE.
REQ-011 SHALL drive imem_req_o=1 only in FETCH, with imem_addr_o=pc; addr SHALL stay stable until ready=1.
REQ-012 In FETCH with ready=1, no kill pending, IFIDStall_i=0 and PCWrite_i=1: SHALL load IF/ID with {pc, imem_data_i, valid=1} and set pc<=pc+4 (mod 2^32, wraps 0xFFFFFFFC->0); remain in FETCH.
REQ-013 In FETCH with ready=1, no kill pending, and (IFIDStall_i=1 or PCWrite_i=0): SHALL capture {pc, data} into a one-entry buffer, hold pc and IF/ID, and move to HOLD.
REQ-014 In HOLD with IFIDStall_i=0 and PCWrite_i=1: SHALL move buffer into IF/ID (valid=1), pc<=pc+4, return to FETCH; otherwise hold everything.
REQ-015 In FETCH with ready=0 and IFIDStall_i=0: SHALL load a bubble into IF/ID (valid=0, instr=NOP 0x00000013, pc unchanged).
REQ-016 IFIDStall_i=1 without flush SHALL keep IF/ID unchanged in every state.
REQ-017 IFIDFlush_i=1 SHALL take priority over stall: IF/ID <= bubble; buffer invalidated; pc<=branch_target_i; HOLD->FETCH.
REQ-018 Flush in FETCH with ready=1 SHALL drop that cycle's data; next request uses branch_target_i.
REQ-019 Flush in FETCH with ready=0 SHALL keep req/addr stable, set kill flag, store target; the completing transfer SHALL be discarded, then pc<=stored target, kill cleared.
REQ-020 A second flush while kill is set SHALL overwrite the stored target.
REQ-021 Latency: instruction appears on IF/ID outputs the cycle after its ready=1 transfer when unstalled.

Reset
REQ-022 On rst_i=0 at a clock edge: state=IDLE, pc=0, imem_req_o=0, pc_IFID_o=0, instr_IFID_o=NOP, valid_IFID_o=0, buffer invalid, kill=0; applies mid-transaction, abandoning any pending request.

Structure
REQ-023 Shared package fetch_pkg SHALL hold the state enum, PC_RESET=0, PC_STEP=4, NOP=0x00000013.
REQ-024 The IF/ID register with stall/flush/bubble SHALL be a sub-module ifid_reg; FSM, PC and buffer remain in fetch_unit.

Verification
REQ-025 Reset, start_i=1, ready always 1 -> addr 0,4,8 on successive cycles; IF/ID valid with pc 0,4,8 one cycle later.
REQ-026 ready=1, IFIDStall_i=PCWrite_i low for 2 cycles at pc=8 -> IF/ID holds pc 4; buffer holds 8; on release IF/ID shows pc 8, next addr 12.
REQ-027 Flush with target 0x100 while stalled in HOLD -> IF/ID valid=0 NOP, buffer dropped, next addr 0x100.
REQ-028 Request at 0x20 with ready=0, flush target 0x200, ready after 3 cycles -> addr stays 0x20, data discarded, next addr 0x200.
REQ-029 Wrap: pc=0xFFFFFFFC fetched -> next addr 0x00000000.
REQ-030 rst_i=0 during pending request -> next cycle req=0, pc=0, IF/ID cleared, state IDLE.
